// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared state encodings and sizing helpers for the sequential multiplier
package seq_mult_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/mult_sign_fix.sv
// mult_sign_fix: conditional two's-complement negate
module mult_sign_fix #(parameter int W = 8) (
  input  logic [W-1:0] d,
  input  logic         neg,
  output logic [W-1:0] q
);
  always_comb q = neg ? -d : d;
endmodule

// File: rtl/seq_mult.sv
// seq_mult: shift-add multiplier, one partial product per clock, signed/unsigned per operation
module seq_mult import seq_mult_pkg::*; #(parameter int N = 8) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         SIGNED,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [2*N-1:0] M
);
  localparam int CW = cnt_width(N);
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [N-1:0] mcand, a_mag, b_mag;
  logic [2*N-1:0] p, p_step, m_fix;
  logic [N:0] sum;
  logic neg, last, accept;
  mult_sign_fix #(.W(N)) u_fix_a (.d(A), .neg(SIGNED & A[N-1]), .q(a_mag));
  mult_sign_fix #(.W(N)) u_fix_b (.d(B), .neg(SIGNED & B[N-1]), .q(b_mag));
  mult_sign_fix #(.W(2*N)) u_fix_m (.d(p_step), .neg(neg), .q(m_fix));
  always_comb begin
    accept = (state == ST_IDLE) & IN_VALID;
    last = (cnt == CW'(1));
    sum = {1'b0, p[2*N-1:N]} + {1'b0, p[0] ? mcand : '0};
    p_step = {sum, p[N-1:1]};
    IN_READY = (state == ST_IDLE);
    OUT_VALID = (state == ST_DONE);
    nxt = (state == ST_IDLE) ? (IN_VALID ? ST_RUN : ST_IDLE) :
          (state == ST_RUN) ? (last ? ST_DONE : ST_RUN) :
          (state == ST_DONE) ? (OUT_READY ? ST_IDLE : ST_DONE) : ST_IDLE;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= ST_IDLE;
    else state <= nxt;
  // Upper half of p accumulates, lower half holds the remaining multiplier bits.
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      cnt <= '0;
      mcand <= '0;
      p <= '0;
      neg <= 1'b0;
      M <= '0;
    end else if (accept) begin
      cnt <= CW'(N);
      mcand <= a_mag;
      p <= {{N{1'b0}}, b_mag};
      neg <= SIGNED & (A[N-1] ^ B[N-1]);
    end else if (state == ST_RUN) begin
      cnt <= cnt - CW'(1);
      p <= p_step;
      if (last) M <= m_fix;
    end
endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult: directed and exhaustive checks of seq_mult at N=8 and N=4
module tb_seq_mult;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic s;
    logic [15:0] m;
  } vec_t;
  logic clk = 0, rst = 1;
  logic v8 = 0, or8 = 0, s8 = 0, rdy8, ov8;
  logic [7:0] a8 = 0, b8 = 0;
  logic [15:0] m8;
  logic v4 = 0, or4 = 0, s4 = 0, rdy4, ov4;
  logic [3:0] a4 = 0, b4 = 0;
  logic [7:0] m4;
  int checks = 0, errors = 0, maxlat = 0;
  always #5 clk = ~clk;
  seq_mult #(.N(8)) dut8 (.CLK(clk), .RST(rst), .IN_VALID(v8), .IN_READY(rdy8), .A(a8), .B(b8),
    .SIGNED(s8), .OUT_VALID(ov8), .OUT_READY(or8), .M(m8));
  seq_mult #(.N(4)) dut4 (.CLK(clk), .RST(rst), .IN_VALID(v4), .IN_READY(rdy4), .A(a4), .B(b4),
    .SIGNED(s4), .OUT_VALID(ov4), .OUT_READY(or4), .M(m4));
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s, output int lat);
    int w = 0;
    while (!rdy8 && w < 50) begin @(posedge clk); #1; w++; end
    a8 = a; b8 = b; s8 = s; v8 = 1;
    @(posedge clk); #1;
    v8 = 0; a8 = ~a; b8 = a ^ b; s8 = ~s;
    chk("in_ready_low_after_accept", rdy8, 0);
    lat = 0;
    while (!ov8 && lat < 40) begin @(posedge clk); #1; lat++; end
    if (lat > maxlat) maxlat = lat;
  endtask
  task automatic release8();
    or8 = 1;
    @(posedge clk); #1;
    or8 = 0;
    chk("in_ready_after_release", rdy8, 1);
    chk("out_valid_after_release", ov8, 0);
  endtask
  initial begin
    vec_t vt[10];
    int lat;
    logic [15:0] held;
    vt[0] = '{8'd255, 8'd255, 1'b0, 16'd65025};
    vt[1] = '{8'hFD, 8'd7, 1'b1, 16'hFFEB};
    vt[2] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vt[3] = '{8'd0, 8'hFF, 1'b1, 16'h0000};
    vt[4] = '{8'd3, 8'd5, 1'b0, 16'd15};
    vt[5] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    vt[6] = '{8'h80, 8'd2, 1'b0, 16'h0100};
    vt[7] = '{8'h7F, 8'h80, 1'b1, 16'hC080};
    vt[8] = '{8'hFF, 8'd1, 1'b1, 16'hFFFF};
    vt[9] = '{8'h80, 8'h80, 1'b0, 16'h4000};
    #3;
    chk("reset_in_ready", rdy8, 1);
    chk("reset_out_valid", ov8, 0);
    chk("reset_m", m8, 0);
    #9 rst = 0;
    @(posedge clk); #1;
    chk("post_reset_in_ready", rdy8, 1);
    for (int i = 0; i < 10; i++) begin
      op8(vt[i].a, vt[i].b, vt[i].s, lat);
      chk($sformatf("vec%0d_m", i), m8, vt[i].m);
      chk($sformatf("vec%0d_latency", i), lat, 8);
      release8();
      chk($sformatf("vec%0d_m_kept", i), m8, vt[i].m);
    end
    // backpressure: DONE held 5 cycles, IN_VALID pulses ignored
    op8(8'd12, 8'd11, 1'b0, lat);
    chk("bp_m", m8, 16'd132);
    for (int c = 0; c < 5; c++) begin
      a8 = 8'd99; b8 = 8'd99; v8 = c[0];
      @(posedge clk); #1;
      chk("bp_m_stable", m8, 16'd132);
      chk("bp_out_valid_stable", ov8, 1);
      chk("bp_in_ready_low", rdy8, 0);
    end
    v8 = 0;
    release8();
    chk("bp_m_after_release", m8, 16'd132);
    // async reset in the middle of RUN
    a8 = 8'd9; b8 = 8'd9; s8 = 0; v8 = 1;
    @(posedge clk); #1;
    v8 = 0;
    repeat (3) @(posedge clk);
    #3 rst = 1;
    #1;
    chk("midrun_rst_in_ready", rdy8, 1);
    chk("midrun_rst_out_valid", ov8, 0);
    chk("midrun_rst_m", m8, 0);
    #2 rst = 0;
    @(posedge clk); #1;
    chk("after_rst_idle", rdy8, 1);
    op8(8'hF9, 8'd6, 1'b1, lat);
    chk("after_rst_m", m8, 16'hFFD6);
    chk("after_rst_latency", lat, 8);
    release8();
    // N=4 exhaustive, both modes
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          int ea, eb, w;
          logic [7:0] exp;
          ea = (s == 1 && a > 7) ? a - 16 : a;
          eb = (s == 1 && b > 7) ? b - 16 : b;
          exp = 8'(ea * eb);
          a4 = 4'(a); b4 = 4'(b); s4 = s[0]; v4 = 1;
          @(posedge clk); #1;
          v4 = 0; a4 = ~a4;
          w = 0;
          while (!ov4 && w < 20) begin @(posedge clk); #1; w++; end
          checks++;
          if (m4 !== exp || w != 4) begin
            errors++;
            $display("FAIL n4 s=%0d a=%0d b=%0d: got %0h after %0d cycles expected %0h after 4", s, a, b, m4, w, exp);
          end
          or4 = 1;
          @(posedge clk); #1;
          or4 = 0;
        end
    chk("max_latency_n8", maxlat, 8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
